// File: rtl/tm1638_if.sv
// TM1638 serial pin bundle (STB/CLK/DIO), seen from the master and the device side.
interface tm1638_if;
  logic tm_cs;
  logic tm_clk;
  logic tm_dio_in;
  logic tm_dio_out;
  logic tm_dio_oe;

  modport master (
    output tm_cs,
    output tm_clk,
    output tm_dio_in,
    input  tm_dio_out,
    input  tm_dio_oe
  );

  modport slave (
    input  tm_cs,
    input  tm_clk,
    input  tm_dio_in,
    output tm_dio_out,
    output tm_dio_oe
  );
endinterface

// File: rtl/tm1638_responder.sv
// Device-side TM1638 model: oversampled STB/CLK/DIO decode into a 16-byte display RAM and
// display-control registers, with key-scan bytes shifted back on read frames.
module tm1638_responder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  tm1638_if.slave           tm,
  input  logic [31:0]       key_scan,
  input  logic [3:0]        ram_raddr,
  output logic [7:0]        ram_rdata,
  output logic              disp_on,
  output logic [2:0]        brightness,
  output logic              update,
  output logic              frame_err
);

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StSkip} state_e;

  localparam logic [7:0] FlushLen = 8'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] cs_sync, clk_sync, dio_sync;
  logic cs_s, clk_s, dio_s, cs_prev, clk_prev;
  logic cs_rise_q, cs_fall_q, sclk_rise_q, sclk_fall_q, dio_q;
  logic [7:0] flush_q;
  logic armed_q;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dio_s = dio_sync[SYNC_STAGES-1];

  // Edges are only trusted once the chain has flushed and STB has been seen high, so an
  // STB still low after reset cannot fake a frame start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs_sync     <= '1;
      clk_sync    <= '1;
      dio_sync    <= '0;
      cs_prev     <= 1'b1;
      clk_prev    <= 1'b1;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      dio_q       <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], tm.tm_cs};
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], tm.tm_clk};
      dio_sync    <= {dio_sync[SYNC_STAGES-2:0], tm.tm_dio_in};
      cs_prev     <= cs_s;
      clk_prev    <= clk_s;
      cs_rise_q   <= armed_q & cs_s & ~cs_prev;
      cs_fall_q   <= armed_q & ~cs_s & cs_prev;
      sclk_rise_q <= armed_q & clk_s & ~clk_prev;
      sclk_fall_q <= armed_q & ~clk_s & clk_prev;
      dio_q       <= dio_s;
      if (flush_q != FlushLen) begin
        flush_q <= flush_q + 8'd1;
      end else if (cs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  state_e     state_q;
  logic [7:0] ram_q [16];
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] addr_q;
  logic       wmode_read_q, fixed_q, dirty_q;
  logic [7:0] rd_sh_q;
  logic [2:0] rd_bit_q;
  logic [1:0] rd_byte_q;
  logic       rd_first_q;
  logic       dio_out_q, dio_oe_q;
  logic [7:0] byte_w;
  logic [1:0] rd_next;
  logic [4:0] rd_base;

  assign byte_w     = {dio_q, shift_q[7:1]};
  assign rd_next    = rd_byte_q + 2'd1;
  assign rd_base    = {rd_next, 3'b000};
  assign ram_rdata  = ram_q[ram_raddr];
  assign tm.tm_dio_out = dio_out_q;
  assign tm.tm_dio_oe  = dio_oe_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      for (int i = 0; i < 16; i++) ram_q[i] <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      addr_q       <= '0;
      wmode_read_q <= 1'b0;
      fixed_q      <= 1'b0;
      dirty_q      <= 1'b0;
      rd_sh_q      <= '0;
      rd_bit_q     <= '0;
      rd_byte_q    <= '0;
      rd_first_q   <= 1'b0;
      dio_out_q    <= 1'b0;
      dio_oe_q     <= 1'b0;
      disp_on      <= 1'b0;
      brightness   <= '0;
      update       <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      update    <= 1'b0;
      frame_err <= 1'b0;
      if (cs_rise_q) begin
        state_q   <= StIdle;
        dio_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
        if (bit_cnt_q != 3'd0) frame_err <= 1'b1;
        if (dirty_q) begin
          update  <= 1'b1;
          dirty_q <= 1'b0;
        end
      end else if (cs_fall_q) begin
        if (state_q == StIdle) begin
          state_q   <= StCmd;
          bit_cnt_q <= '0;
        end
      end else if (state_q != StIdle) begin
        if (sclk_rise_q) begin
          shift_q   <= byte_w;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (state_q)
              StCmd: begin
                case (byte_w[7:6])
                  2'b01: begin
                    wmode_read_q <= byte_w[1];
                    fixed_q      <= byte_w[2];
                    rd_first_q   <= 1'b1;
                    state_q      <= byte_w[1] ? StRdata : StSkip;
                  end
                  2'b10: begin
                    disp_on    <= byte_w[3];
                    brightness <= byte_w[2:0];
                    dirty_q    <= 1'b1;
                    state_q    <= StSkip;
                  end
                  2'b11: begin
                    addr_q  <= byte_w[3:0];
                    state_q <= StWdata;
                  end
                  default: begin
                    frame_err <= 1'b1;
                    state_q   <= StSkip;
                  end
                endcase
              end
              StWdata: begin
                if (wmode_read_q) begin
                  frame_err <= 1'b1;
                end else begin
                  ram_q[addr_q] <= byte_w;
                  dirty_q       <= 1'b1;
                  if (!fixed_q) addr_q <= addr_q + 4'd1;
                end
              end
              default: ;
            endcase
          end
        end
        if (sclk_fall_q && state_q == StRdata) begin
          // A fresh key byte is latched at every byte boundary so the host sees live keys.
          if (rd_first_q) begin
            rd_first_q <= 1'b0;
            dio_oe_q   <= 1'b1;
            rd_byte_q  <= '0;
            rd_sh_q    <= key_scan[7:0];
            dio_out_q  <= key_scan[0];
            rd_bit_q   <= 3'd1;
          end else if (rd_bit_q == 3'd0) begin
            rd_byte_q  <= rd_next;
            rd_sh_q    <= key_scan[rd_base +: 8];
            dio_out_q  <= key_scan[rd_base];
            rd_bit_q   <= 3'd1;
          end else begin
            dio_out_q  <= rd_sh_q[rd_bit_q];
            rd_bit_q   <= rd_bit_q + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: a bit-banged master drives frames, expected RAM and
// key bytes go through a scoreboard queue and are checked as the DUT produces them.
module tb_tm1638_responder;
  localparam int H = 80;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] key_scan;
  logic [3:0]  ram_raddr;
  logic [7:0]  ram_rdata;
  logic        disp_on;
  logic [2:0]  brightness;
  logic        update;
  logic        frame_err;

  tm1638_if bus ();

  tm1638_responder #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tm         (bus.slave),
    .key_scan   (key_scan),
    .ram_raddr  (ram_raddr),
    .ram_rdata  (ram_rdata),
    .disp_on    (disp_on),
    .brightness (brightness),
    .update     (update),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mram [16];

  always @(posedge clk) begin
    if (update) upd_cnt <= upd_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, obs}, {24'd0, e});
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 16; i++) exp_q.push_back(mram[i]);
    for (int i = 0; i < 16; i++) begin
      ram_raddr = 4'(i);
      #1;
      pop_chk($sformatf("%s ram[%0d]", tag, i), ram_rdata);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.tm_clk    = 1'b0;
      bus.tm_dio_in = b[i];
      #H;
      bus.tm_clk    = 1'b1;
      #H;
    end
  endtask

  task automatic recv_bits(output logic [7:0] b, input int n);
    b = '0;
    for (int i = 0; i < n; i++) begin
      bus.tm_clk = 1'b0;
      #H;
      bus.tm_clk = 1'b1;
      b[i] = bus.tm_dio_out;
      #H;
    end
  endtask

  task automatic frame_start();
    bus.tm_cs = 1'b0;
    #H;
  endtask

  task automatic frame_end();
    #H;
    bus.tm_cs = 1'b1;
    #(4 * H);
  endtask

  task automatic cmd_frame(input logic [7:0] c);
    frame_start();
    send_bits(c, 8);
    frame_end();
  endtask

  int u0, e0;
  logic [7:0] rb;

  initial begin
    bus.tm_cs = 1'b1;
    bus.tm_clk = 1'b1;
    bus.tm_dio_in = 1'b0;
    key_scan = '0;
    ram_raddr = '0;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mram[i] = 8'h00;
    #3;
    #50;
    chk("reset oe", {31'd0, bus.tm_dio_oe}, 32'd0);
    chk("reset dout", {31'd0, bus.tm_dio_out}, 32'd0);
    chk("reset disp_on", {31'd0, disp_on}, 32'd0);
    chk("reset brightness", {29'd0, brightness}, 32'd0);
    chk("reset update", {31'd0, update}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    check_ram("reset");
    rst = 1'b1;
    #100;

    // Auto-increment fill of all 16 bytes.
    u0 = upd_cnt; e0 = err_cnt;
    cmd_frame(8'h40);
    frame_start();
    send_bits(8'hC0, 8);
    for (int i = 0; i < 16; i++) begin
      send_bits(8'(i + 1), 8);
      mram[i] = 8'(i + 1);
    end
    frame_end();
    chk("fill update count", 32'(upd_cnt - u0), 32'd1);
    chk("fill frame_err count", 32'(err_cnt - e0), 32'd0);
    check_ram("fill");

    // Fixed address: both bytes land at 5.
    u0 = upd_cnt;
    cmd_frame(8'h44);
    frame_start();
    send_bits(8'hC5, 8);
    send_bits(8'hAA, 8);
    send_bits(8'h55, 8);
    frame_end();
    mram[5] = 8'h55;
    chk("fixed update count", 32'(upd_cnt - u0), 32'd1);
    check_ram("fixed");

    // Auto-increment wraps from F to 0.
    cmd_frame(8'h40);
    frame_start();
    send_bits(8'hCE, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    frame_end();
    mram[14] = 8'h11; mram[15] = 8'h22; mram[0] = 8'h33;
    check_ram("wrap");

    // Display control.
    u0 = upd_cnt;
    cmd_frame(8'h8C);
    chk("ctrl disp_on", {31'd0, disp_on}, 32'd1);
    chk("ctrl brightness", {29'd0, brightness}, 32'd4);
    chk("ctrl update count", 32'(upd_cnt - u0), 32'd1);

    // Key read with byte-index wrap.
    key_scan = 32'h11_00_10_01;
    e0 = err_cnt;
    exp_q.push_back(8'h01); exp_q.push_back(8'h10); exp_q.push_back(8'h00);
    exp_q.push_back(8'h11); exp_q.push_back(8'h01);
    frame_start();
    send_bits(8'h42, 8);
    for (int k = 0; k < 5; k++) begin
      recv_bits(rb, 8);
      pop_chk($sformatf("key byte %0d", k), rb);
    end
    chk("read oe active", {31'd0, bus.tm_dio_oe}, 32'd1);
    frame_end();
    chk("read oe released", {31'd0, bus.tm_dio_oe}, 32'd0);
    chk("read frame_err count", 32'(err_cnt - e0), 32'd0);

    // Data write while in read mode is ignored and flagged.
    u0 = upd_cnt; e0 = err_cnt;
    frame_start();
    send_bits(8'hC0, 8);
    send_bits(8'h99, 8);
    frame_end();
    chk("write-in-read err", 32'(err_cnt - e0), 32'd1);
    chk("write-in-read update", 32'(upd_cnt - u0), 32'd0);
    check_ram("write-in-read");

    // Truncated byte.
    cmd_frame(8'h40);
    u0 = upd_cnt; e0 = err_cnt;
    frame_start();
    send_bits(8'hC3, 8);
    send_bits(8'hFF, 5);
    frame_end();
    chk("partial err", 32'(err_cnt - e0), 32'd1);
    chk("partial update", 32'(upd_cnt - u0), 32'd0);
    check_ram("partial");

    // Illegal command class 00.
    e0 = err_cnt;
    cmd_frame(8'h3F);
    chk("cmd 3F err", 32'(err_cnt - e0), 32'd1);

    // Reset in the middle of a read frame.
    frame_start();
    send_bits(8'h42, 8);
    recv_bits(rb, 3);
    chk("pre-reset oe", {31'd0, bus.tm_dio_oe}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset mid-read oe", {31'd0, bus.tm_dio_oe}, 32'd0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    u0 = upd_cnt; e0 = err_cnt;
    recv_bits(rb, 8);
    chk("post-reset oe still low", {31'd0, bus.tm_dio_oe}, 32'd0);
    frame_end();
    chk("post-reset err", 32'(err_cnt - e0), 32'd0);
    chk("post-reset update", 32'(upd_cnt - u0), 32'd0);
    chk("post-reset disp_on", {31'd0, disp_on}, 32'd0);
    for (int i = 0; i < 16; i++) mram[i] = 8'h00;
    check_ram("post-reset");
    frame_start();
    send_bits(8'hC0, 8);
    send_bits(8'h77, 8);
    frame_end();
    mram[0] = 8'h77;
    check_ram("new frame");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
